// File: rtl/sram_bist_pkg.sv
// Shared types and the March C- element table
// for the SRAM BIST controller.
package sram_bist_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_M4,
    S_M5,
    S_CHK,
    S_DONE
  } state_t;

  localparam logic [31:0] DATA0 = 32'h0000_0000;
  localparam logic [31:0] DATA1 = 32'hFFFF_FFFF;

  typedef struct packed {
    logic       dn;
    logic       rd;
    logic       rval;
    logic       wr;
    logic       wval;
    logic [1:0] ops;
  } elem_t;

  // dn, rd, rval, wr, wval, ops
  localparam elem_t ELEM [8] = '{
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2},
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2},
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2},
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2},
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}
  };

  function automatic logic [2:0] elem_idx(
    input state_t s
  );
    case (s)
      S_M1:    return 3'd1;
      S_M2:    return 3'd2;
      S_M3:    return 3'd3;
      S_M4:    return 3'd4;
      S_M5:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic state_t next_elem(
    input state_t s
  );
    case (s)
      S_M0:    return S_M1;
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      S_M4:    return S_M5;
      default: return S_CHK;
    endcase
  endfunction

  function automatic logic is_march(
    input state_t s
  );
    return s inside {S_M0, S_M1, S_M2,
                     S_M3, S_M4, S_M5};
  endfunction

endpackage

// File: rtl/sram_march_bist_addr_gen.sv
// Loadable up/down address counter with
// terminal-count flag for the BIST sequencer.
module bist_addr_gen
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int LAST_ADDR = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ld,
  input  logic              i_ld_dn,
  input  logic              i_step,
  input  logic              i_dn,
  output logic [ADDR_W-1:0] o_nxt,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(LAST_ADDR);

  logic [ADDR_W-1:0] r_addr;

  assign o_tc = i_dn ? (r_addr == '0)
                     : (r_addr == LAST);

  always_comb begin
    o_nxt = r_addr;
    if (i_ld)
      o_nxt = i_ld_dn ? LAST : '0;
    else if (i_step)
      o_nxt = i_dn ? r_addr - 1'b1
                   : r_addr + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_addr <= '0;
    else
      r_addr <= o_nxt;
  end

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller driving a 1-cycle
// latency synchronous SRAM port.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int LAST_ADDR = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              CS,
  output logic              OE,
  output logic [3:0]        WEB,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       DI,
  input  logic [31:0]       DO,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [31:0]       fail_exp,
  output logic [31:0]       fail_obs
);

  state_t            r_state;
  state_t            w_nxt;
  logic              r_ph;
  logic              w_nxt_ph;
  logic [2:0]        w_ci;
  logic [2:0]        w_ni;
  logic              w_ld;
  logic              w_ld_dn;
  logic              w_step;
  logic              w_dn;
  logic              w_tc;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic              w_mis;
  logic              w_go;
  logic              w_nacc;
  logic              w_nrd;
  logic              w_nwr;

  logic              r_cs;
  logic              r_oe;
  logic [3:0]        r_web;
  logic [ADDR_W-1:0] r_a;
  logic [31:0]       r_di;
  logic              r_cmp_vld;
  logic [31:0]       r_cmp_exp;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [31:0]       r_fail_exp;
  logic [31:0]       r_fail_obs;

  assign CS        = r_cs;
  assign OE        = r_oe;
  assign WEB       = r_web;
  assign A         = r_a;
  assign DI        = r_di;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_exp  = r_fail_exp;
  assign fail_obs  = r_fail_obs;

  assign busy = is_march(r_state) ||
                (r_state == S_CHK);
  assign done = (r_state == S_DONE);
  assign w_ci = elem_idx(r_state);
  assign w_dn = ELEM[w_ci].dn;

  bist_addr_gen #(
    .ADDR_W   (ADDR_W),
    .LAST_ADDR(LAST_ADDR)
  ) u_addr (
    .clk    (clk),
    .rst_n  (rst),
    .i_ld   (w_ld),
    .i_ld_dn(w_ld_dn),
    .i_step (w_step),
    .i_dn   (w_dn),
    .o_nxt  (w_nxt_addr),
    .o_tc   (w_tc)
  );

  always_comb begin
    w_nxt    = r_state;
    w_nxt_ph = r_ph;
    w_ld     = 1'b0;
    w_step   = 1'b0;
    w_mis    = busy && r_cmp_vld &&
               (DO != r_cmp_exp);
    w_go     = start &&
               (r_state == S_IDLE ||
                r_state == S_DONE);
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_nxt    = S_M0;
          w_nxt_ph = 1'b0;
          w_ld     = 1'b1;
        end
      end
      S_CHK: w_nxt = S_DONE;
      S_M0, S_M1, S_M2,
      S_M3, S_M4, S_M5: begin
        if (w_mis) begin
          w_nxt    = S_DONE;
          w_nxt_ph = 1'b0;
        end else if (ELEM[w_ci].ops == 2'd2
                     && !r_ph) begin
          w_nxt_ph = 1'b1;
        end else begin
          w_nxt_ph = 1'b0;
          if (w_tc) begin
            w_nxt = next_elem(r_state);
            w_ld  = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    w_ni    = elem_idx(w_nxt);
    w_ld_dn = ELEM[w_ni].dn;
    w_nacc  = is_march(w_nxt);
    // single-op elements ignore the phase bit
    w_nrd   = w_nacc && ELEM[w_ni].rd &&
              (ELEM[w_ni].ops == 2'd1 ||
               !w_nxt_ph);
    w_nwr   = w_nacc && ELEM[w_ni].wr &&
              (ELEM[w_ni].ops == 2'd1 ||
               w_nxt_ph);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ph        <= 1'b0;
      r_cs        <= 1'b0;
      r_oe        <= 1'b0;
      r_web       <= 4'hF;
      r_a         <= '0;
      r_di        <= '0;
      r_cmp_vld   <= 1'b0;
      r_cmp_exp   <= '0;
      r_cmp_addr  <= '0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_obs  <= '0;
    end else begin
      r_state    <= w_nxt;
      r_ph       <= w_nxt_ph;
      r_cs       <= is_march(w_nxt) ||
                    (w_nxt == S_CHK);
      r_oe       <= w_nrd;
      r_web      <= w_nwr ? 4'h0 : 4'hF;
      r_a        <= (w_nrd || w_nwr) ?
                    w_nxt_addr : '0;
      r_di       <= (w_nwr && ELEM[w_ni].wval)
                    ? DATA1 : DATA0;
      r_cmp_vld  <= r_oe;
      r_cmp_exp  <= ELEM[w_ci].rval ?
                    DATA1 : DATA0;
      r_cmp_addr <= r_a;
      if (w_go) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_exp  <= '0;
        r_fail_obs  <= '0;
      end else if (w_mis) begin
        r_fail      <= 1'b1;
        r_fail_addr <= r_cmp_addr;
        r_fail_exp  <= r_cmp_exp;
        r_fail_obs  <= DO;
      end
    end
  end

endmodule
